// File: rtl/jtag_shift_reg.sv
// JTAG-style WIDTH-bit data register: capture, LSB-first serial shift, update latch.
// Define JSR_BYPASS_EN to add a 1-bit bypass path that freezes the data register.
module jtag_shift_reg #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int unsigned       CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             shift_en,
  input  logic             update_en,
  input  logic             tdi,
  input  logic [WIDTH-1:0] par_in,
  output logic             tdo,
  output logic [WIDTH-1:0] par_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_done
`ifdef JSR_BYPASS_EN
  ,
  input  logic             bypass
`endif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic             frozen;
  logic             do_capture;
  logic             do_shift;
  logic             do_update;

`ifdef JSR_BYPASS_EN
  logic byp;

  assign frozen = bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp <= 1'b0;
    end else if (bypass) begin
      if (capture_en) begin
        byp <= 1'b0;
      end else if (shift_en) begin
        byp <= tdi;
      end
    end
  end

  assign tdo = bypass ? byp : sr[0];
`else
  assign frozen = 1'b0;
  assign tdo    = sr[0];
`endif

  // Capture wins over shift; everything in the data path stalls while bypassed.
  assign do_capture = capture_en & ~frozen;
  assign do_shift   = shift_en & ~capture_en & ~frozen;
  assign do_update  = update_en & ~frozen;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; update_en therefore latches the old sr even when a
  // shift or capture happens in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (do_capture) begin
      sr <= par_in;
    end else if (do_shift) begin
      sr <= {tdi, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_out <= RESET_VAL;
    end else if (do_update) begin
      par_out <= sr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt <= '0;
    end else if (do_capture) begin
      shift_cnt <= '0;
    end else if (do_shift && shift_cnt != CNT_FULL) begin
      shift_cnt <= shift_cnt + CNT_W'(1);
    end
  end

  // Pulse only on the WIDTH-1 -> WIDTH transition; saturated shifts do not re-fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_done <= 1'b0;
    end else if (!frozen) begin
      shift_done <= do_shift && (shift_cnt == CNT_LAST);
    end
  end

endmodule
